median_stream_filter: RTL and testbench

- Streaming sliding-window median filter for 4-bit unsigned samples.
- Accepts one sample per valid/ready handshake into a WIN-deep shift window and emits the median of the current window through a one-entry output register.
- Sits directly upstream of the combinational median stage: it supplies the windowed operands and buffers that stage's result for a downstream consumer.

---
 rtl/median_pkg.sv | 11 +
 rtl/median_sort_core.sv | 31 +++
 rtl/median_stream_filter.sv | 110 +++++++++++
 tb/tb_median_stream_filter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants and types for the streaming median filter.
package median_pkg;

  localparam int unsigned DEFAULT_DW  = 4;
  localparam int unsigned DEFAULT_WIN = 7;

  typedef enum logic {FILL, RUN} state_t;

  typedef logic [DEFAULT_DW-1:0] sample_t;

endpackage

// File: rtl/median_sort_core.sv
// Combinational WIN-input median: odd-even transposition network of
// compare-exchange pairs, with the middle-rank element as the result.
module median_sort_core #(
  parameter int unsigned DW  = 4,
  parameter int unsigned WIN = 7
) (
  input  logic [WIN*DW-1:0] i_win,
  output logic [DW-1:0]     o_median
);

  always_comb begin
    logic [DW-1:0] v [WIN];
    logic [DW-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      v[i] = i_win[i*DW +: DW];
    end
    // WIN alternating even/odd rounds fully sort any WIN-element input.
    for (int unsigned s = 0; s < WIN; s++) begin
      for (int unsigned i = s % 2; i + 1 < WIN; i += 2) begin
        if (v[i] > v[i+1]) begin
          t      = v[i];
          v[i]   = v[i+1];
          v[i+1] = t;
        end
      end
    end
    o_median = v[(WIN-1)/2];
  end

endmodule

// File: rtl/median_stream_filter.sv
// Sliding-window median filter with valid/ready handshake and one-entry output register.
// Optional feature: MEDIAN_EDGE_REPLICATE_EN seeds the whole window from the first sample.
module median_stream_filter
  import median_pkg::*;
#(
  parameter int unsigned DW  = DEFAULT_DW,
  parameter int unsigned WIN = DEFAULT_WIN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  if (!(WIN == 3 || WIN == 5 || WIN == 7)) begin : g_bad_win
    $error("median_stream_filter: WIN must be 3, 5 or 7");
  end

  localparam int unsigned CW = $clog2(WIN + 1);

  logic [DW-1:0]     r_win [WIN];
  logic [CW-1:0]     r_cnt;
  state_t            r_state;
  logic              r_out_valid;
  logic [DW-1:0]     r_out_data;

  logic              w_acc;
  logic              w_cons;
  logic              w_load;
  logic [DW-1:0]     w_load_data;
  logic [DW-1:0]     w_median;
  logic [WIN*DW-1:0] w_next_win;

  assign in_ready  = !r_out_valid || out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign w_acc     = in_valid && in_ready;
  assign w_cons    = r_out_valid && out_ready;

  // Median operates on the window as it will look after this cycle's shift.
  always_comb begin
    w_next_win = '0;
    w_next_win[DW-1:0] = in_data;
    for (int unsigned i = 1; i < WIN; i++) begin
      w_next_win[i*DW +: DW] = r_win[i-1];
    end
  end

  median_sort_core #(
    .DW  (DW),
    .WIN (WIN)
  ) u_sort (
    .i_win    (w_next_win),
    .o_median (w_median)
  );

`ifdef MEDIAN_EDGE_REPLICATE_EN
  assign w_load      = w_acc;
  assign w_load_data = (r_state == FILL) ? in_data : w_median;
`else
  assign w_load      = w_acc && (r_state == RUN || r_cnt == CW'(WIN - 1));
  assign w_load_data = w_median;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIN; i++) begin
        r_win[i] <= '0;
      end
      r_cnt       <= '0;
      r_state     <= FILL;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_acc) begin
        r_win[0] <= in_data;
        for (int unsigned i = 1; i < WIN; i++) begin
          r_win[i] <= r_win[i-1];
        end
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
      end else if (w_cons) begin
        r_out_valid <= 1'b0;
      end

      if (w_acc && r_state == FILL) begin
`ifdef MEDIAN_EDGE_REPLICATE_EN
        for (int unsigned i = 0; i < WIN; i++) begin
          r_win[i] <= in_data;
        end
        r_cnt   <= CW'(WIN);
        r_state <= RUN;
`else
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIN - 1)) begin
          r_state <= RUN;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_median_stream_filter.sv
// Self-checking bench for median_stream_filter against a queue-based median model.
module tb_median_stream_filter;
  import median_pkg::*;

  localparam int unsigned WIN = 7;
  localparam int unsigned DW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // Model: accepted samples, newest first, trimmed to the window length.
  sample_t hist[$];
  logic    m_valid = 1'b0;
  sample_t m_data = '0;
  logic    exp_ready;
  logic    obs_ready;

  median_stream_filter #(.DW(DW), .WIN(WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic sample_t ref_median();
    sample_t a [WIN];
    sample_t t;
    for (int i = 0; i < WIN; i++) a[i] = hist[i];
    for (int i = 1; i < WIN; i++) begin
      for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    end
    return a[(WIN-1)/2];
  endfunction

  task automatic drive(input logic v, input sample_t d, input logic r);
    logic acc;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    exp_ready = !m_valid || r;
    obs_ready = in_ready;
    acc = v && exp_ready;
    @(posedge clk);
    if (acc) begin
      hist.push_front(d);
`ifdef MEDIAN_EDGE_REPLICATE_EN
      if (hist.size() == 1) repeat (WIN - 1) hist.push_front(d);
`endif
      if (hist.size() > WIN) void'(hist.pop_back());
    end
    if (acc && hist.size() == WIN) begin
      m_valid = 1'b1;
      m_data  = ref_median();
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input logic v, input logic r);
    rst       = 1'b1;
    in_valid  = v;
    in_data   = sample_t'($urandom);
    out_ready = r;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    hist.delete();
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 4'd0) begin failures++; $display("FAIL reset_data: got %0d expected 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 7; i++) begin
      drive(1'b1, sample_t'(i), 1'b1);
      checks++;
      if (obs_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, obs_ready); end
      if (i < 7) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_novalid[%0d]: got %b expected 0", i, out_valid); end
      end else begin
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_data !== 4'd4) begin failures++; $display("FAIL fill_median: got %0d expected 4", out_data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd15, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd5) begin
      failures++; $display("FAIL b2b_15: got v=%b d=%0d expected v=1 d=5", out_valid, out_data);
    end
    drive(1'b1, 4'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd5) begin
      failures++; $display("FAIL b2b_0: got v=%b d=%0d expected v=1 d=5", out_valid, out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    logic [DW-1:0] exp_seq [3];
    exp_seq[0] = 4'd6; exp_seq[1] = 4'd7; exp_seq[2] = 4'd9;
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd9, 1'b0);
      checks++;
      if (obs_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, obs_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        failures++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d expected v=1 d=%0d", i, out_valid, out_data, held);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd9, 1'b1);
      checks++;
      if (obs_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready[%0d]: got %b expected 1", i, obs_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
        failures++; $display("FAIL bp_release[%0d]: got v=%b d=%0d expected v=1 d=%0d", i, out_valid, out_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_duplicates();
    logic [DW-1:0] seq [7];
    seq[0] = 4'd3; seq[1] = 4'd3; seq[2] = 4'd3; seq[3] = 4'd0;
    seq[4] = 4'd15; seq[5] = 4'd15; seq[6] = 4'd15;
    for (int i = 0; i < 7; i++) drive(1'b1, seq[i], 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd3) begin
      failures++; $display("FAIL dup_median: got v=%b d=%0d expected v=1 d=3", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    if (out_valid !== 1'b1) drive(1'b1, sample_t'($urandom), 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
    do_reset(1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 4'd0) begin failures++; $display("FAIL midrst_data: got %0d expected 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", in_ready); end
`ifndef MEDIAN_EDGE_REPLICATE_EN
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, sample_t'($urandom), 1'b1);
      checks++;
      if (out_valid !== (i == 6)) begin
        failures++; $display("FAIL midrst_refill[%0d]: got %b expected %b", i, out_valid, (i == 6));
      end
    end
    checks++;
    if (out_data !== m_data) begin failures++; $display("FAIL midrst_refill_data: got %0d expected %0d", out_data, m_data); end
`endif
  endtask

  task automatic test_random();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), sample_t'($urandom), ($urandom_range(0, 3) != 0));
      checks++;
      if (obs_ready !== exp_ready) begin
        failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready);
      end
      checks++;
      if (out_valid !== m_valid || out_data !== m_data) begin
        failures++; $display("FAIL rand_out[%0d]: got v=%b d=%0d expected v=%b d=%0d", i, out_valid, out_data, m_valid, m_data);
      end
    end
  endtask

`ifdef MEDIAN_EDGE_REPLICATE_EN
  task automatic test_replicate();
    logic [DW-1:0] din [5];
    logic [DW-1:0] dexp [5];
    din[0] = 4'd9; din[1] = 4'd0; din[2] = 4'd0; din[3] = 4'd0; din[4] = 4'd0;
    dexp[0] = 4'd9; dexp[1] = 4'd9; dexp[2] = 4'd9; dexp[3] = 4'd9; dexp[4] = 4'd0;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, din[i], 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== dexp[i]) begin
        failures++; $display("FAIL replicate[%0d]: got v=%b d=%0d expected v=1 d=%0d", i, out_valid, out_data, dexp[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef MEDIAN_EDGE_REPLICATE_EN
    test_fill();
    test_back_to_back();
    test_backpressure();
    test_duplicates();
`else
    test_replicate();
`endif
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
